gpio_irq: RTL
=============

# gpio_irq

Input-conditioning and interrupt stage placed between the GPIO pads and the CPU interrupt line. It takes raw pad input bits, synchronises and optionally debounces them, and detects level or edge events per pin. Events are latched into a pending register and merged into a single `irq` output. The conditioned pin values are also driven back to the GPIO block as its read value. Software controls the block through its own byte-offset register window on the slave bus.

## Interface
- `WIDTH`, 8: number of pins.
- `DB_CYCLES`, 16: debounce length in cycles, minimum 2.
- `clk`  in  1: the single clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `bus`  slave_bus_if.slave  –: register port.
  - `bus.ss` qualifies an access; `bus.we` selects write.
  - `bus.addr[7:0]` is the byte offset; `bus.wdata`/`bus.rdata` are 32-bit.
  - `bus.bdone` is held at 1.
- `pin_in`  in  WIDTH: raw pad input values, asynchronous.
- `pin_sync`  out  WIDTH: debounced pin state, equal to the STATE register.
- `irq`  out  1: registered interrupt, equal to `|(PENDING & IE)`.

## Operation
- **Register map.** Reads return data zero-extended to 32 bits. Unmapped reads return 0; unmapped writes are ignored.
  - 0x00 STATE: read-only, debounced level.
  - 0x04 IE: interrupt enable.
  - 0x08 TYPE: 1 = edge, 0 = level.
  - 0x0C POL: 1 = rising/high, 0 = falling/low.
  - 0x10 BOTH: 1 = both edges; edge mode only.
  - 0x14 PENDING: read; write-1-to-clear, edge pins only.
  - 0x18 DBEN: per-pin debounce enable.
- **Synchroniser.** Two flops per pin: `s1 <= pin_in`, `s2 <= s1`.
- **Debounce, DBEN=0.** `deb <= s2`.
- **Debounce, DBEN=1.** Per-pin counter `cnt`:
  - If `s2 == deb`: `cnt <= 0`.
  - Else, if `cnt == DB_CYCLES-1`: `deb <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Any mismatch shorter than DB_CYCLES consecutive cycles is rejected.
- **Edge detection.** `deb_q <= deb`.
  - `rise = deb & ~deb_q`, `fall = ~deb & deb_q`.
  - Edge event = `BOTH ? (rise|fall) : (POL ? rise : fall)`.
- **Level pin (TYPE=0).** PENDING bit is loaded every cycle with `deb == POL`. W1C has no effect on level pins.
- **Edge pin (TYPE=1).** PENDING bit is set by an edge event and cleared by a W1C write. If a set and a W1C fall in the same cycle, the set wins.
- **Configuration writes.** Any write to TYPE, POL or BOTH clears all edge PENDING bits. Edge events in that same cycle are dropped.
- **IE.** Masks `irq` only; PENDING is latched regardless of IE.
- **Bus.** All accesses complete in one cycle. Read data is combinational from `bus.addr`. Writes commit at posedge `clk` when `bus.ss && bus.we`.

## Timing
- **Reset values.** All registers, `s1`, `s2`, `deb`, `deb_q`, `cnt` and PENDING are 0; `pin_sync` = 0 and `irq` = 0.
- **Post-reset.** Defaults are TYPE=0 and POL=0, so low pins show as level-pending. `irq` stays 0 because IE=0.
- **Pipeline**, for a `pin_in` change sampled at edge E0:
  - `s1` at E1, `s2` at E2.
  - `deb`/`pin_sync` at E3 (DBEN=0) or E(2+DB_CYCLES) (DBEN=1).
  - PENDING one edge after `deb`; `irq` one edge after PENDING.
- **Register-driven changes.**
  - A W1C or IE write at edge Ew changes `irq` at Ew+1.
  - A write to DBEN mid-count zeroes `cnt` for the affected pins.
- **Reset mid-operation.** `rst_n` low at any edge returns all state to reset values at that edge, including any partially counted debounce.

## Structure
- Package `gpio_irq_pkg` holds:
  - register offset localparams (`GPIO_IRQ_STATE` … `GPIO_IRQ_DBEN`);
  - the default `WIDTH`.
- Sub-module `gpio_debounce` contains the synchroniser, counter and `deb` for one pin.
  - Ports: `clk`, `rst_n`, `en`, `in`, `out`.
  - Instantiated WIDTH times under `generate`.
- Top level holds the register file, edge logic, PENDING and `irq`.

## Test plan
- **Reset.** Hold `rst_n`=0 with `pin_in`=0xFF → all reads 0, `irq`=0. Release → STATE=0xFF after 3 cycles.
- **Edge, no debounce.** TYPE=0x01, POL=0x01, IE=0x01, DBEN=0; raise `pin_in[0]` at E0 → PENDING=0x01 at E4, `irq`=1 at E5. W1C 0x01 → `irq`=0 next cycle.
- **Debounce.** DBEN=0x02, DB_CYCLES=16:
  - 10-cycle high pulse on `pin_in[1]` → STATE bit1 never set.
  - 20-cycle pulse → STATE bit1=1 at E18.
- **Level / both-edge.**
  - TYPE=0, POL=0x04, IE=0x04, `pin_in[2]`=1 → `irq` stays high after W1C 0x04; drops 2 cycles after `deb` falls.
  - BOTH=0x08 with TYPE bit3=1 → pending on both rise and fall.
- **Simultaneous.** W1C of bit0 in the same cycle as a new rise on pin 0 → PENDING bit0 remains 1. Write to POL → all edge pending bits cleared.
- **Reset mid-debounce.** Assert `rst_n`=0 at `cnt`=8 → STATE stays 0 after release until a fresh 16-cycle-stable input is seen.

Source files
------------

// File: rtl/gpio_irq_pkg.sv
// -----------------------------------------------------------------------------
// gpio_irq_pkg
// Shared definitions for the GPIO input-conditioning / interrupt block:
//   - default pin count and debounce length
//   - byte offsets of the software-visible registers
//   - a register-select enum and the address decoder that produces it
// -----------------------------------------------------------------------------
package gpio_irq_pkg;

  // Default number of pins and debounce length (cycles).
  localparam int GPIO_IRQ_WIDTH     = 8;
  localparam int GPIO_IRQ_DB_CYCLES = 16;

  // Register byte offsets inside the block's window.
  localparam logic [7:0] GPIO_IRQ_STATE   = 8'h00;
  localparam logic [7:0] GPIO_IRQ_IE      = 8'h04;
  localparam logic [7:0] GPIO_IRQ_TYPE    = 8'h08;
  localparam logic [7:0] GPIO_IRQ_POL     = 8'h0C;
  localparam logic [7:0] GPIO_IRQ_BOTH    = 8'h10;
  localparam logic [7:0] GPIO_IRQ_PENDING = 8'h14;
  localparam logic [7:0] GPIO_IRQ_DBEN    = 8'h18;

  // One-hot-free register selector produced by the address decoder.
  typedef enum logic [2:0] {
    REG_STATE   = 3'd0,
    REG_IE      = 3'd1,
    REG_TYPE    = 3'd2,
    REG_POL     = 3'd3,
    REG_BOTH    = 3'd4,
    REG_PENDING = 3'd5,
    REG_DBEN    = 3'd6,
    REG_NONE    = 3'd7
  } gpio_irq_reg_e;

  // Map a byte offset onto a register; anything unmapped is REG_NONE.
  function automatic gpio_irq_reg_e gpio_irq_decode(input logic [7:0] addr);
    gpio_irq_reg_e sel;
    case (addr)
      GPIO_IRQ_STATE:   sel = REG_STATE;
      GPIO_IRQ_IE:      sel = REG_IE;
      GPIO_IRQ_TYPE:    sel = REG_TYPE;
      GPIO_IRQ_POL:     sel = REG_POL;
      GPIO_IRQ_BOTH:    sel = REG_BOTH;
      GPIO_IRQ_PENDING: sel = REG_PENDING;
      GPIO_IRQ_DBEN:    sel = REG_DBEN;
      default:          sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/gpio_irq_if.sv
// -----------------------------------------------------------------------------
// slave_bus_if
// Simple single-cycle register bus.
//   ss     : access qualifier
//   we     : 1 = write, 0 = read
//   addr   : byte offset within the slave window
//   wdata  : write data
//   rdata  : read data (combinational from addr in the slave)
//   bdone  : access complete (this slave always completes in one cycle)
// -----------------------------------------------------------------------------
interface slave_bus_if;
  logic        ss;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        bdone;

  modport master (
    output ss, we, addr, wdata,
    input  rdata, bdone
  );

  modport slave (
    input  ss, we, addr, wdata,
    output rdata, bdone
  );
endinterface

// File: rtl/gpio_irq_debounce.sv
// -----------------------------------------------------------------------------
// gpio_debounce
// One pin of input conditioning: two-flop synchroniser followed by an optional
// debounce filter. With en=0 the output follows the synchronised input one
// cycle later. With en=1 the output only changes once the synchronised input
// has disagreed with it for DB_CYCLES consecutive cycles.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   en    : debounce enable
//   in    : raw asynchronous pad value
//   out   : conditioned (registered) pin value
// -----------------------------------------------------------------------------
module gpio_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic in,
  output logic out
);

  localparam int                CNT_W   = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

  logic             s1_r;
  logic             s2_r;
  logic             deb_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchroniser, mismatch counter and debounced level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r  <= 1'b0;
      s2_r  <= 1'b0;
      deb_r <= 1'b0;
      cnt_r <= CNT_ZERO;
    end else begin
      s1_r <= in;
      s2_r <= s1_r;
      if (!en) begin
        // Filter bypassed: counter held at zero so re-enabling starts fresh.
        deb_r <= s2_r;
        cnt_r <= CNT_ZERO;
      end else if (s2_r == deb_r) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r == CNT_MAX) begin
        // DB_CYCLES-th consecutive disagreement: accept the new level.
        deb_r <= s2_r;
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign out = deb_r;

endmodule

// File: rtl/gpio_irq.sv
// -----------------------------------------------------------------------------
// gpio_irq
// Input conditioning and interrupt generation for WIDTH GPIO pins.
// Each pin is synchronised and optionally debounced (gpio_debounce), then
// checked for level or edge events. Events latch into PENDING, and the
// enabled pending bits are OR-ed into a registered irq.
// Ports:
//   clk      : clock
//   rst_n    : synchronous active-low reset
//   bus      : slave register port (STATE/IE/TYPE/POL/BOTH/PENDING/DBEN)
//   pin_in   : raw asynchronous pad values
//   pin_sync : conditioned pin values (same as STATE)
//   irq      : registered interrupt, |(PENDING & IE)
// -----------------------------------------------------------------------------
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int WIDTH     = GPIO_IRQ_WIDTH,
  parameter int DB_CYCLES = GPIO_IRQ_DB_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  slave_bus_if.slave       bus,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_sync,
  output logic             irq
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  // Software registers.
  logic [WIDTH-1:0] ie_r;
  logic [WIDTH-1:0] type_r;
  logic [WIDTH-1:0] pol_r;
  logic [WIDTH-1:0] both_r;
  logic [WIDTH-1:0] dben_r;
  logic [WIDTH-1:0] pend_r;
  logic             irq_r;

  // Conditioned pin levels and their one-cycle-delayed copy.
  logic [WIDTH-1:0] deb_s;
  logic [WIDTH-1:0] deb_q_r;

  // Bus decode.
  gpio_irq_reg_e    sel_s;
  logic             wr_s;
  logic [WIDTH-1:0] wr_data_s;
  logic             cfg_wr_s;
  logic [WIDTH-1:0] w1c_s;

  // Event and pending next-state.
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] edge_ev_s;
  logic [WIDTH-1:0] edge_next_s;
  logic [WIDTH-1:0] level_next_s;
  logic [WIDTH-1:0] pend_next_s;
  logic [WIDTH-1:0] rd_val_s;

  // Per-bit edge event selection: BOTH overrides POL.
  function automatic logic [WIDTH-1:0] edge_event(
    input logic [WIDTH-1:0] rise,
    input logic [WIDTH-1:0] fall,
    input logic [WIDTH-1:0] pol,
    input logic [WIDTH-1:0] both
  );
    return (both & (rise | fall)) | (~both & ((pol & rise) | (~pol & fall)));
  endfunction

  // ---------------------------------------------------------------------------
  // Per-pin conditioning
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
    gpio_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (dben_r[gi]),
      .in    (pin_in[gi]),
      .out   (deb_s[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  assign sel_s     = gpio_irq_decode(bus.addr);
  assign wr_s      = bus.ss & bus.we;
  assign wr_data_s = bus.wdata[WIDTH-1:0];

  // Write-strobe decode: configuration-change and W1C masks.
  always_comb begin
    cfg_wr_s = 1'b0;
    w1c_s    = ZERO_W;
    if (wr_s) begin
      case (sel_s)
        REG_TYPE, REG_POL, REG_BOTH: cfg_wr_s = 1'b1;
        REG_PENDING:                 w1c_s    = wr_data_s;
        default:                     cfg_wr_s = 1'b0;
      endcase
    end else begin
      cfg_wr_s = 1'b0;
      w1c_s    = ZERO_W;
    end
  end

  // ---------------------------------------------------------------------------
  // Event detection and pending next-state
  // ---------------------------------------------------------------------------
  assign rise_s    = deb_s & ~deb_q_r;
  assign fall_s    = ~deb_s & deb_q_r;
  assign edge_ev_s = edge_event(rise_s, fall_s, pol_r, both_r);

  // Edge bits: a config write wipes them (and drops same-cycle events);
  // otherwise a new event wins over a simultaneous W1C.
  // Level bits: reloaded every cycle from the current level match.
  always_comb begin
    level_next_s = ~(deb_s ^ pol_r);
    if (cfg_wr_s) begin
      edge_next_s = ZERO_W;
    end else begin
      edge_next_s = (pend_r & ~w1c_s) | edge_ev_s;
    end
    pend_next_s = (type_r & edge_next_s) | (~type_r & level_next_s);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Software-writable configuration registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ie_r   <= ZERO_W;
      type_r <= ZERO_W;
      pol_r  <= ZERO_W;
      both_r <= ZERO_W;
      dben_r <= ZERO_W;
    end else if (wr_s) begin
      case (sel_s)
        REG_IE:   ie_r   <= wr_data_s;
        REG_TYPE: type_r <= wr_data_s;
        REG_POL:  pol_r  <= wr_data_s;
        REG_BOTH: both_r <= wr_data_s;
        REG_DBEN: dben_r <= wr_data_s;
        default:  ie_r   <= ie_r;
      endcase
    end
  end

  // Edge history, pending bits and the interrupt output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_q_r <= ZERO_W;
      pend_r  <= ZERO_W;
      irq_r   <= 1'b0;
    end else begin
      deb_q_r <= deb_s;
      pend_r  <= pend_next_s;
      irq_r   <= |(pend_r & ie_r);
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux (combinational, zero-extended)
  // ---------------------------------------------------------------------------
  // Select register contents for the addressed offset.
  always_comb begin
    case (sel_s)
      REG_STATE:   rd_val_s = deb_s;
      REG_IE:      rd_val_s = ie_r;
      REG_TYPE:    rd_val_s = type_r;
      REG_POL:     rd_val_s = pol_r;
      REG_BOTH:    rd_val_s = both_r;
      REG_PENDING: rd_val_s = pend_r;
      REG_DBEN:    rd_val_s = dben_r;
      default:     rd_val_s = ZERO_W;
    endcase
    bus.rdata                = 32'd0;
    bus.rdata[WIDTH-1:0]     = rd_val_s;
  end

  assign bus.bdone = 1'b1;
  assign pin_sync  = deb_s;
  assign irq       = irq_r;

endmodule
